// File: rtl/pipelined_core_pkg.sv
// pipelined_core_pkg: opcodes, instruction field positions and decoded instruction type for the 4-stage core
package pipelined_core_pkg;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_LOAD = 3'd2, OP_STORE = 3'd3,
                         OP_AND = 3'd4, OP_OR = 3'd5, OP_BEQ = 3'd6, OP_HALT = 3'd7;
  localparam int OP_MSB = 15, RD_MSB = 12, RS1_MSB = 9, RS2_MSB = 6, IMM_MSB = 3;
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [3:0] imm;
  } instr_t;
  function automatic logic writes_reg(logic [2:0] op);
    return !(op == OP_STORE || op == OP_BEQ || op == OP_HALT);
  endfunction
endpackage

// File: rtl/pipe_regfile.sv
// pipe_regfile: 8 x DATA_W registers, two async reads with write-through, one sync write, r0 hardwired to zero
module pipe_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [2:0]        wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [2:0]        ra1_i,
  input  logic [2:0]        ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o
);
  logic [DATA_W-1:0] regs_q [8];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    else if (we_i && wa_i != 3'd0) regs_q[wa_i] <= wd_i;
  always_comb begin
    rd1_o = ra1_i == 3'd0 ? '0 : (we_i && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
    rd2_o = ra2_i == 3'd0 ? '0 : (we_i && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];
  end
endmodule

// File: rtl/pipelined_core_fwd.sv
// pipelined_core_fwd: IF/ID/EX/WB core with WB->EX forwarding, branch flush, stores, HALT and retire counter
module pipelined_core_fwd
  import pipelined_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              halted,
  output logic [CNT_W-1:0]  instret,
  output logic              wb_valid,
  output logic [2:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
);
  logic [PC_W-1:0] pc_q, pc_d, fd_pc_q, de_pc_q;
  logic fd_v_q, fd_v_d, de_v_q, de_v_d, ew_v_q, halted_q, halted_d;
  logic [15:0] fd_ir_q;
  instr_t de_ir_q, de_ir_d;
  logic [DATA_W-1:0] de_a_q, de_b_q, rd1, rd2, op_a, op_b, alu_res, ew_res_q;
  logic [2:0] ew_op_q, ew_rd_q;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic taken, halt_ex, flush;
  pipe_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk(clk), .rst(rst), .we_i(wb_valid), .wa_i(ew_rd_q), .wd_i(ew_res_q),
    .ra1_i(fd_ir_q[RS1_MSB-:3]), .ra2_i(fd_ir_q[RS2_MSB-:3]), .rd1_o(rd1), .rd2_o(rd2)
  );
  always_comb begin
    de_ir_d = '{op: fd_ir_q[OP_MSB-:3], rd: fd_ir_q[RD_MSB-:3], rs1: fd_ir_q[RS1_MSB-:3],
                rs2: fd_ir_q[RS2_MSB-:3], imm: fd_ir_q[IMM_MSB-:4]};
    op_a = (wb_valid && wb_rd != 3'd0 && wb_rd == de_ir_q.rs1) ? wb_data : de_a_q;
    op_b = (wb_valid && wb_rd != 3'd0 && wb_rd == de_ir_q.rs2) ? wb_data : de_b_q;
    alu_res = de_ir_q.op == OP_ADD  ? op_a + op_b :
              de_ir_q.op == OP_SUB  ? op_a - op_b :
              de_ir_q.op == OP_LOAD ? dmem_rdata :
              de_ir_q.op == OP_AND  ? op_a & op_b : op_a | op_b;
    taken = de_v_q && de_ir_q.op == OP_BEQ && op_a == op_b;
    halt_ex = de_v_q && de_ir_q.op == OP_HALT;
    // once halted the flush stays asserted so the frozen pc never refetches into valid state
    flush = taken || halt_ex || halted_q;
    pc_d = (halt_ex || halted_q) ? pc_q :
           taken ? de_pc_q + PC_W'($signed(de_ir_q.imm)) : pc_q + PC_W'(1);
    fd_v_d = !flush;
    de_v_d = fd_v_q && !flush;
    halted_d = halted_q || halt_ex;
    instret_d = (de_v_q && instret_q != '1) ? instret_q + CNT_W'(1) : instret_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q      <= '0;
      fd_v_q    <= 1'b0;
      fd_pc_q   <= '0;
      fd_ir_q   <= '0;
      de_v_q    <= 1'b0;
      de_pc_q   <= '0;
      de_ir_q   <= '0;
      de_a_q    <= '0;
      de_b_q    <= '0;
      ew_v_q    <= 1'b0;
      ew_op_q   <= '0;
      ew_rd_q   <= '0;
      ew_res_q  <= '0;
      halted_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      pc_q      <= pc_d;
      fd_v_q    <= fd_v_d;
      fd_pc_q   <= pc_q;
      fd_ir_q   <= imem_data;
      de_v_q    <= de_v_d;
      de_pc_q   <= fd_pc_q;
      de_ir_q   <= de_ir_d;
      de_a_q    <= rd1;
      de_b_q    <= rd2;
      ew_v_q    <= de_v_q;
      ew_op_q   <= de_ir_q.op;
      ew_rd_q   <= de_ir_q.rd;
      ew_res_q  <= alu_res;
      halted_q  <= halted_d;
      instret_q <= instret_d;
    end
  assign imem_addr  = pc_q;
  assign dmem_addr  = op_a;
  assign dmem_wdata = op_b;
  assign dmem_we    = de_v_q && de_ir_q.op == OP_STORE && !halted_q;
  assign halted     = halted_q;
  assign instret    = instret_q;
  assign wb_valid   = ew_v_q && writes_reg(ew_op_q);
  assign wb_rd      = ew_rd_q;
  assign wb_data    = ew_res_q;
endmodule

// File: tb/tb_pipelined_core_fwd.sv
// tb_pipelined_core_fwd: directed checks of pipelined_core_fwd against hand-computed expectations
module tb_pipelined_core_fwd;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, LD = 3'd2, ST = 3'd3, BEQ = 3'd6, HLT = 3'd7;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] imem_addr;
  logic [15:0] imem_data;
  logic [7:0] dmem_addr, dmem_wdata, dmem_rdata, wb_data;
  logic dmem_we, halted, wb_valid;
  logic [15:0] instret;
  logic [2:0] wb_rd;
  logic [15:0] imem [16];
  logic [7:0] dmem [256];
  int n_tests = 0, n_fail = 0;
  pipelined_core_fwd #(.DATA_W(8), .PC_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
    .halted(halted), .instret(instret), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );
  always #5 clk = ~clk;
  assign imem_data  = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  always @(posedge clk) if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
  function automatic logic [15:0] enc(logic [2:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2, logic [3:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic rst_on();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) imem[i] = enc(HLT, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
  endtask
  task automatic rst_off();
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic chk_reset(string tag);
    chk({tag, "_pc"}, imem_addr, 0);
    chk({tag, "_instret"}, instret, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_wbv"}, wb_valid, 0);
    chk({tag, "_wbrd"}, wb_rd, 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    chk({tag, "_we"}, dmem_we, 0);
  endtask
  initial begin
    // 1: loads then dependent add
    rst_on();
    imem[0] = enc(LD, 1, 0, 0, 0);
    imem[1] = enc(LD, 2, 0, 0, 0);
    imem[2] = enc(ADD, 3, 1, 2, 0);
    dmem[0] = 8'd5;
    rst_off();
    chk_reset("rst");
    step(2);
    chk("t1_no_early_retire", wb_valid, 0);
    step(1);
    chk("t1_first_retire", {wb_valid, wb_rd}, {1'b1, 3'd1});
    chk("t1_first_data", wb_data, 5);
    chk("t1_instret1", instret, 1);
    step(2);
    chk("t1_r3", {wb_valid, wb_rd}, {1'b1, 3'd3});
    chk("t1_r3_data", wb_data, 8'h0a);
    chk("t1_instret3", instret, 3);
    // 2: back-to-back forwarding on both operands
    rst_on();
    imem[0] = enc(LD, 4, 0, 0, 0);
    imem[1] = enc(LD, 1, 0, 0, 0);
    imem[2] = enc(ADD, 1, 0, 0, 0);
    imem[3] = enc(SUB, 2, 1, 4, 0);
    imem[4] = enc(ADD, 3, 2, 2, 0);
    dmem[0] = 8'd3;
    rst_off();
    step(5);
    chk("t2_r1", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd1, 8'h00});
    step(1);
    chk("t2_r2", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd2, 8'hfd});
    step(1);
    chk("t2_r3", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd3, 8'hfa});
    chk("t2_instret", instret, 5);
    // 3: taken branch flushes the two younger instructions
    rst_on();
    imem[0] = enc(LD, 1, 0, 0, 0);
    imem[1] = enc(ADD, 2, 1, 1, 0);
    imem[2] = enc(ADD, 6, 0, 0, 0);
    imem[3] = enc(ADD, 3, 1, 0, 0);
    imem[4] = enc(BEQ, 0, 0, 0, 4'hf);
    imem[5] = enc(ADD, 7, 1, 1, 0);
    imem[6] = enc(ST, 0, 0, 1, 0);
    dmem[0] = 8'd5;
    rst_off();
    step(4);
    chk("t3_r2", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd2, 8'h0a});
    step(2);
    chk("t3_pc_before", imem_addr, 6);
    chk("t3_we_beq", dmem_we, 0);
    step(1);
    chk("t3_pc_target", imem_addr, 3);
    chk("t3_beq_wbv", wb_valid, 0);
    chk("t3_instret_beq", instret, 5);
    for (int i = 0; i < 2; i++) begin
      step(1);
      chk("t3_bubble_wbv", wb_valid, 0);
      chk("t3_bubble_we", dmem_we, 0);
      chk("t3_bubble_instret", instret, 5);
    end
    step(1);
    chk("t3_loop_r3", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd3, 8'h05});
    chk("t3_loop_instret", instret, 6);
    chk("t3_mem_untouched", dmem[0], 5);
    // 6a: reset asserted while the second branch flush is in flight
    step(1);
    #2 rst = 1'b1;
    #1 chk_reset("t6a");
    rst_off();
    chk("t6a_pc0", imem_addr, 0);
    step(3);
    chk("t6a_restart", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd1, 8'h05});
    chk("t6a_instret", instret, 1);
    // 4 + 5: store/load round trip, then HALT
    rst_on();
    imem[0] = enc(LD, 1, 0, 0, 0);
    imem[1] = enc(LD, 2, 1, 0, 0);
    imem[2] = enc(SUB, 2, 2, 1, 0);
    imem[3] = enc(ST, 0, 1, 2, 0);
    imem[4] = enc(LD, 5, 1, 0, 0);
    imem[5] = enc(ADD, 6, 5, 5, 0);
    imem[6] = enc(HLT, 0, 0, 0, 0);
    imem[7] = enc(ADD, 1, 5, 5, 0);
    dmem[0] = 8'd2;
    dmem[2] = 8'd9;
    rst_off();
    step(4);
    chk("t4_we_before", dmem_we, 0);
    step(1);
    chk("t4_store", {dmem_we, dmem_addr, dmem_wdata}, {1'b1, 8'd2, 8'd7});
    step(1);
    chk("t4_we_after", dmem_we, 0);
    chk("t4_store_no_wb", wb_valid, 0);
    chk("t4_store_instret", instret, 4);
    step(1);
    chk("t4_r5", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd5, 8'd7});
    chk("t4_mem", dmem[2], 7);
    step(1);
    chk("t5_r6", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd6, 8'h0e});
    chk("t5_not_yet_halted", halted, 0);
    step(1);
    chk("t5_halted", halted, 1);
    chk("t5_pc_frozen", imem_addr, 8);
    chk("t5_instret", instret, 7);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("t5_hold_wbv", wb_valid, 0);
      chk("t5_hold_instret", instret, 7);
      chk("t5_hold_pc", imem_addr, 8);
      chk("t5_hold_halted", halted, 1);
    end
    // 6b: reset while halted
    #2 rst = 1'b1;
    #1 chk_reset("t6b");
    rst_off();
    step(3);
    chk("t6b_restart", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd1, 8'h02});
    chk("t6b_instret", instret, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
